// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_DM = 1'b1
  } gnt_e;

  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the IF and DM pipeline ports onto one single-port memory.
// Optional ARB_RR_EN macro: round-robin tie-break instead of fixed DM priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              stall_f,
  output logic              stall_m,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        dbg_state
);

  // Handshake: a port raises *_req and holds it until its one-cycle *_ready.
  // Once issued, an access always completes; dropping req early does not cancel it.

  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LAT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  gnt_e              gnt_q, gnt_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  gnt_e              pick;
  logic              issue;
  logic              capture;

`ifdef ARB_RR_EN
  gnt_e last_q, last_d;

  always_comb begin
    if (if_req && dm_req) begin
      pick = (last_q == GNT_DM) ? GNT_IF : GNT_DM;
    end else begin
      pick = dm_req ? GNT_DM : GNT_IF;
    end
    last_d = issue ? pick : last_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= GNT_DM;
    end else begin
      last_q <= last_d;
    end
  end
`else
  always_comb begin
    pick = dm_req ? GNT_DM : GNT_IF;
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    we_d    = we_q;
    issue   = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (if_req || dm_req) begin
          issue = 1'b1;
          gnt_d = pick;
          we_d  = (pick == GNT_DM) && dm_we;
          cnt_d = LAT_M1;
          if (MEM_LAT == 1) begin
            state_d = RESP;
            capture = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        // Memory data is valid in the last WAIT cycle; counter saturates at 0.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
        if (cnt_q <= CNT_W'(1)) begin
          state_d = RESP;
          capture = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    if (capture) begin
      if (gnt_d == GNT_IF) begin
        if_rdata_d = mem_rdata;
      end else if (!we_d) begin
        dm_rdata_d = mem_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      gnt_q      <= GNT_DM;
      we_q       <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      we_q       <= we_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  // Reset masks the strobes so an aborted access never leaks a pulse.
  assign mem_en    = issue && !reset;
  assign mem_we    = mem_en && we_d;
  assign mem_addr  = (pick == GNT_DM) ? dm_addr : if_addr;
  assign mem_wdata = dm_wdata;

  assign if_ready  = (state_q == RESP) && (gnt_q == GNT_IF) && !reset;
  assign dm_ready  = (state_q == RESP) && (gnt_q == GNT_DM) && !reset;
  assign stall_f   = if_req && !if_ready;
  assign stall_m   = dm_req && !dm_ready;

  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (MEM_LAT=2 main instance, MEM_LAT=1 side instance).
module tb_mem_port_arbiter;

  localparam int LAT = 2;
`ifdef ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- main DUT (MEM_LAT=2) ----------------
  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_ready, dm_ready, stall_f, stall_m, mem_en, mem_we;
  logic [1:0]  dbg_state;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .stall_f(stall_f), .stall_m(stall_m),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // ---------------- side DUT (MEM_LAT=1) ----------------
  logic        if_req1, dm_req1, dm_we1;
  logic [31:0] if_addr1, dm_addr1, dm_wdata1, mem_rdata1;
  logic [31:0] if_rdata1, dm_rdata1, mem_addr1, mem_wdata1;
  logic        if_ready1, dm_ready1, stall_f1, stall_m1, mem_en1, mem_we1;
  logic [1:0]  dbg_state1;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut1 (
    .clk(clk), .reset(reset),
    .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1), .if_ready(if_ready1),
    .dm_req(dm_req1), .dm_we(dm_we1), .dm_addr(dm_addr1), .dm_wdata(dm_wdata1),
    .dm_rdata(dm_rdata1), .dm_ready(dm_ready1),
    .stall_f(stall_f1), .stall_m(stall_m1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .dbg_state(dbg_state1)
  );

  // ---------------- memory environment ----------------
  logic [31:0] mem_arr [logic [31:0]];
  logic [31:0] rd_pipe;

  function automatic logic [31:0] mem_init(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_0000;
  endfunction

  function automatic logic [31:0] env_rd(input logic [31:0] a);
    return mem_arr.exists(a) ? mem_arr[a] : mem_init(a);
  endfunction

  // Read data appears in cycle T+1 only; other cycles carry junk.
  always @(posedge clk) begin
    if (mem_en) begin
      rd_pipe <= env_rd(mem_addr);
      if (mem_we) mem_arr[mem_addr] = mem_wdata;
    end else begin
      rd_pipe <= $urandom;
    end
  end
  assign mem_rdata  = rd_pipe;
  assign mem_rdata1 = mem_en1 ? (mem_addr1 ^ 32'h1111_0000) : 32'hBAD1_BAD1;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic drop_all();
    if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    string       name;
    logic        if_req, dm_req, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    logic        exp_en, exp_we, exp_dm;
    logic [31:0] exp_addr, exp_wdata, exp_if_rdata, exp_dm_rdata;
  } vec_t;

  vec_t vecs[5];

  // ---------------- random-phase reference model ----------------
  longint      cyc, free_cyc, pend_cyc;
  logic        pend_v, pend_dm, pend_we, last_dm;
  logic [31:0] if_m, dm_m;
  logic        if_done, dm_done;
  logic [31:0] ref_mem [logic [31:0]];

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : mem_init(a);
  endfunction

  function automatic logic [31:0] rand_addr();
    return 32'h400 + (32'($urandom_range(0, 15)) << 2);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] fa, sa, fdata, sdata, dm_hold, a1;
    logic        first_dm;

    reset = 1'b1;
    drop_all();
    if_addr = '0; dm_addr = '0; dm_wdata = '0;
    if_req1 = 1'b0; if_addr1 = '0; dm_req1 = 1'b0; dm_we1 = 1'b0; dm_addr1 = '0; dm_wdata1 = '0;
    mem_arr[32'h4] = 32'hE3A0_1005;
    ref_mem[32'h4] = 32'hE3A0_1005;
    tick();
    tick();
    settle();
    chk("rst_if_ready", if_ready, 0);
    chk("rst_dm_ready", dm_ready, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_dm_rdata", dm_rdata, 0);
    chk("rst_state", 32'(dbg_state), 0);
    chk("rst1_dm_rdata", dm_rdata1, 0);
    chk("rst1_state", 32'(dbg_state1), 0);
    tick();
    reset = 1'b0;

    // ---- table ----
    vecs[0] = '{"if_only", 1, 0, 0, 32'h4, 32'h0, 32'h0,
                1, 0, 0, 32'h4, 32'h0, 32'hE3A0_1005, 32'h0};
    vecs[1] = '{"dm_load", 0, 1, 0, 32'h0, 32'h100, 32'h0,
                1, 0, 1, 32'h100, 32'h0, 32'hE3A0_1005, mem_init(32'h100)};
    vecs[2] = '{"dm_store", 0, 1, 1, 32'h0, 32'h200, 32'hDEAD_BEEF,
                1, 1, 1, 32'h200, 32'hDEAD_BEEF, 32'hE3A0_1005, mem_init(32'h100)};
    vecs[3] = '{"both", 1, 1, 0, 32'h8, 32'h104, 32'h0,
                1, 0, !RR_EN, RR_EN ? 32'h8 : 32'h104, 32'h0,
                RR_EN ? mem_init(32'h8) : 32'hE3A0_1005,
                RR_EN ? mem_init(32'h100) : mem_init(32'h104)};
    vecs[4] = '{"none", 0, 0, 0, 32'h0, 32'h0, 32'h0,
                0, 0, 0, 32'h0, 32'h0, vecs[3].exp_if_rdata, vecs[3].exp_dm_rdata};

    for (int i = 0; i < 5; i++) begin
      if_req = vecs[i].if_req; dm_req = vecs[i].dm_req; dm_we = vecs[i].dm_we;
      if_addr = vecs[i].if_addr; dm_addr = vecs[i].dm_addr; dm_wdata = vecs[i].dm_wdata;
      settle();
      chk({vecs[i].name, "_en"}, mem_en, vecs[i].exp_en);
      if (vecs[i].exp_en) begin
        chk({vecs[i].name, "_we"}, mem_we, vecs[i].exp_we);
        chk({vecs[i].name, "_addr"}, mem_addr, vecs[i].exp_addr);
        if (vecs[i].exp_we) chk({vecs[i].name, "_wdata"}, mem_wdata, vecs[i].exp_wdata);
      end
      chk({vecs[i].name, "_stall_f"}, stall_f, vecs[i].if_req);
      chk({vecs[i].name, "_stall_m"}, stall_m, vecs[i].dm_req);
      for (int k = 1; k <= LAT; k++) begin
        tick();
        settle();
        chk({vecs[i].name, "_en_busy"}, mem_en, 0);
        chk({vecs[i].name, "_if_ready"}, if_ready,
            vecs[i].exp_en && !vecs[i].exp_dm && (k == LAT));
        chk({vecs[i].name, "_dm_ready"}, dm_ready,
            vecs[i].exp_en && vecs[i].exp_dm && (k == LAT));
        chk({vecs[i].name, "_stall_f_busy"}, stall_f,
            vecs[i].if_req && !(vecs[i].exp_en && !vecs[i].exp_dm && (k == LAT)));
      end
      tick();
      drop_all();
      settle();
      chk({vecs[i].name, "_if_rdata"}, if_rdata, vecs[i].exp_if_rdata);
      chk({vecs[i].name, "_dm_rdata"}, dm_rdata, vecs[i].exp_dm_rdata);
      chk({vecs[i].name, "_en_after"}, mem_en, 0);
      tick();
    end

    // ---- simultaneous requests held to completion ----
    do_reset();
    first_dm = !RR_EN;
    fa    = first_dm ? 32'h100 : 32'h10;
    sa    = first_dm ? 32'h10 : 32'h100;
    fdata = env_rd(fa);
    sdata = env_rd(sa);
    if_req = 1; if_addr = 32'h10; dm_req = 1; dm_we = 0; dm_addr = 32'h100;
    settle();
    chk("tie_first_en", mem_en, 1);
    chk("tie_first_addr", mem_addr, fa);
    tick(); settle();
    chk("tie_wait_en", mem_en, 0);
    chk("tie_wait_stall_f", stall_f, 1);
    chk("tie_wait_stall_m", stall_m, 1);
    tick(); settle();
    chk("tie_first_ready", first_dm ? dm_ready : if_ready, 1);
    chk("tie_second_not_ready", first_dm ? if_ready : dm_ready, 0);
    chk("tie_second_stall", first_dm ? stall_f : stall_m, 1);
    chk("tie_first_rdata", first_dm ? dm_rdata : if_rdata, fdata);
    tick();
    if (first_dm) dm_req = 0; else if_req = 0;
    settle();
    chk("tie_second_en", mem_en, 1);
    chk("tie_second_addr", mem_addr, sa);
    chk("tie_second_we", mem_we, 0);
    tick(); settle();
    chk("tie_second_wait", first_dm ? if_ready : dm_ready, 0);
    tick(); settle();
    chk("tie_second_ready", first_dm ? if_ready : dm_ready, 1);
    chk("tie_second_rdata", first_dm ? if_rdata : dm_rdata, sdata);
    tick();
    drop_all();
    dm_hold = mem_init(32'h100);

    // ---- flushed fetch, DM raised meanwhile ----
    if_req = 1; if_addr = 32'h20;
    settle();
    chk("flush_if_en", mem_en, 1);
    chk("flush_if_addr", mem_addr, 32'h20);
    tick();
    if_req = 0; dm_req = 1; dm_we = 1; dm_addr = 32'h204; dm_wdata = 32'h1234_5678;
    settle();
    chk("flush_wait_en", mem_en, 0);
    chk("flush_wait_stall_m", stall_m, 1);
    tick(); settle();
    chk("flush_if_ready", if_ready, 1);
    chk("flush_if_rdata_hold", if_rdata, mem_init(32'h20));
    chk("flush_resp_en", mem_en, 0);
    tick(); settle();
    chk("flush_dm_en", mem_en, 1);
    chk("flush_dm_we", mem_we, 1);
    chk("flush_dm_addr", mem_addr, 32'h204);
    chk("flush_dm_wdata", mem_wdata, 32'h1234_5678);
    tick(); tick(); settle();
    chk("flush_dm_ready", dm_ready, 1);
    chk("flush_dm_rdata_kept", dm_rdata, dm_hold);
    tick();
    drop_all();

    // ---- reset during a load ----
    dm_req = 1; dm_we = 0; dm_addr = 32'h104;
    settle();
    chk("rmid_issue", mem_en, 1);
    tick();
    reset = 1;
    tick(); settle();
    chk("rmid_dm_ready", dm_ready, 0);
    chk("rmid_if_ready", if_ready, 0);
    chk("rmid_mem_en", mem_en, 0);
    chk("rmid_if_rdata", if_rdata, 0);
    chk("rmid_dm_rdata", dm_rdata, 0);
    chk("rmid_state", 32'(dbg_state), 0);
    tick();
    reset = 0;
    settle();
    chk("rmid_reissue_en", mem_en, 1);
    chk("rmid_reissue_addr", mem_addr, 32'h104);
    tick(); settle();
    chk("rmid_wait_ready", dm_ready, 0);
    tick(); settle();
    chk("rmid_ready", dm_ready, 1);
    chk("rmid_rdata", dm_rdata, mem_init(32'h104));
    tick();
    drop_all();

    // ---- MEM_LAT=1 back-to-back fetches ----
    if_req1 = 1; if_addr1 = 32'h40;
    for (int k = 0; k < 6; k++) begin
      settle();
      chk("lat1_en", mem_en1, (k % 2) == 0);
      chk("lat1_ready", if_ready1, (k % 2) == 1);
      chk("lat1_stall_f", stall_f1, (k % 2) == 0);
      chk("lat1_dm_ready", dm_ready1, 0);
      chk("lat1_stall_m", stall_m1, 0);
      if ((k % 2) == 0) begin
        chk("lat1_addr", mem_addr1, if_addr1);
        chk("lat1_we", mem_we1, 0);
      end else begin
        chk("lat1_rdata", if_rdata1, if_addr1 ^ 32'h1111_0000);
      end
      a1 = if_addr1;
      tick();
      if ((k % 2) == 1) if_addr1 = a1 + 32'h4;
    end
    if_req1 = 0;

    // ---- randomized traffic vs reference model ----
    do_reset();
    cyc = 0; free_cyc = 0; pend_cyc = 0; pend_v = 0; pend_dm = 0; pend_we = 0;
    last_dm = 1; if_m = 0; dm_m = 0; if_done = 0; dm_done = 0;
    exp_q.delete();
    for (int n = 0; n < 1500; n++) begin
      logic ex_if_rdy, ex_dm_rdy, ex_issue, ex_dm;
      logic [31:0] a;
      if (if_req) begin
        if (if_done) if_req = 0;
        else if ($urandom_range(0, 19) == 0) if_req = 0;
        else if ($urandom_range(0, 3) == 0) if_addr = rand_addr();
      end else if ($urandom_range(0, 2) == 0) begin
        if_req = 1; if_addr = rand_addr();
      end
      if (dm_req) begin
        if (dm_done) dm_req = 0;
        else if ($urandom_range(0, 3) == 0) begin
          dm_addr = rand_addr(); dm_we = 1'($urandom_range(0, 1)); dm_wdata = $urandom;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        dm_req = 1; dm_addr = rand_addr(); dm_we = 1'($urandom_range(0, 1)); dm_wdata = $urandom;
      end
      settle();
      ex_if_rdy = pend_v && pend_cyc == cyc && !pend_dm;
      ex_dm_rdy = pend_v && pend_cyc == cyc && pend_dm;
      if (ex_if_rdy || ex_dm_rdy) begin
        pend_v = 0;
        if (ex_if_rdy) if_m = exp_q.pop_front();
        else if (!pend_we) dm_m = exp_q.pop_front();
      end
      ex_issue = (cyc >= free_cyc) && (if_req || dm_req);
      ex_dm = (if_req && dm_req) ? (RR_EN ? !last_dm : 1'b1) : dm_req;
      chk("rnd_en", mem_en, ex_issue);
      if (ex_issue) begin
        a = ex_dm ? dm_addr : if_addr;
        chk("rnd_addr", mem_addr, a);
        chk("rnd_we", mem_we, ex_dm && dm_we);
        if (ex_dm && dm_we) begin
          chk("rnd_wdata", mem_wdata, dm_wdata);
          ref_mem[a] = dm_wdata;
        end else begin
          exp_q.push_back(ref_rd(a));
        end
        pend_v = 1; pend_dm = ex_dm; pend_we = ex_dm && dm_we;
        pend_cyc = cyc + LAT; free_cyc = cyc + LAT + 1; last_dm = ex_dm;
      end
      chk("rnd_if_ready", if_ready, ex_if_rdy);
      chk("rnd_dm_ready", dm_ready, ex_dm_rdy);
      chk("rnd_if_rdata", if_rdata, if_m);
      chk("rnd_dm_rdata", dm_rdata, dm_m);
      chk("rnd_stall_f", stall_f, if_req && !ex_if_rdy);
      chk("rnd_stall_m", stall_m, dm_req && !ex_dm_rdy);
      if_done = ex_if_rdy;
      dm_done = ex_dm_rdy;
      cyc++;
      tick();
    end
    drop_all();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
